csa_resolve_unit: RTL and testbench

Iterative carry-propagate resolver at the output of the 32×32 Wallace multiplier. It accepts the redundant sum/carry vector pair from the final carry-save stage, together with the issuing reservation-station tag. It adds the pair one CHUNK-bit slice per cycle and presents the binary 64-bit product, with its tag, to the common-data-bus arbiter through a valid/ready handshake.

---
 rtl/wallace_pkg.sv | 27 ++
 rtl/chunk_adder.sv | 17 +
 rtl/csa_resolve_unit.sv | 196 +++++++++++++++++++
 tb/tb_csa_resolve_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wallace_pkg.sv
// Shared definitions for the Wallace multiplier back end: default
// operand geometry, the resolver state encoding, and a small helper
// for sizing the chunk index register.
package wallace_pkg;

    // Default operand geometry for the 32x32 multiplier.
    localparam int DEF_WIDTH = 64;
    localparam int DEF_CHUNK = 16;
    localparam int DEF_TAG_W = 4;

    // Number of CHUNK-bit slices, which is also the resolve latency.
    localparam int NCHUNK = DEF_WIDTH / DEF_CHUNK;

    // Resolver control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } resolve_state_t;

    // Width of an index that counts 0 .. n-1. This is never narrower
    // than one bit, so a single-chunk build still has a legal register.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// One CHUNK-bit slice of the carry-propagate resolver: a plain ripple
// add with carry in and carry out. The top level shares one instance
// across all slices.
module chunk_adder #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    // (CHUNK+1)-bit sum; the top bit is the slice carry out.
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/csa_resolve_unit.sv
// Iterative carry-propagate resolver for the Wallace multiplier.
// This unit takes the redundant sum/carry pair from the last CSA stage,
// adds it one CHUNK-bit slice per cycle through a single shared
// chunk_adder, and hands the 64-bit product plus its reservation-
// station tag to the CDB arbiter over a valid/ready handshake.
//
// Optional feature: define CSA_RESOLVE_OVF_EN to add the ovf_o port.
// The flag is set when any bit of the upper half of the product is
// nonzero.
module csa_resolve_unit
    import wallace_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_i,
    input  logic [WIDTH-1:0] carry_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] prod_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             cout_o
`ifdef CSA_RESOLVE_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int IDX_W      = idx_bits(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    // Control state.
    resolve_state_t   state_q;
    resolve_state_t   state_d;
    logic [IDX_W-1:0] idx_q;
    logic             cr_q;

    // Latched operands and registered results.
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic [WIDTH-1:0] prod_q;
    logic [TAG_W-1:0] tag_q;
    logic             cout_q;

    // Shared slice adder signals.
    logic [CHUNK-1:0] sum_slice;
    logic [CHUNK-1:0] carry_slice;
    logic [CHUNK-1:0] add_s;
    logic             add_c;
    logic             last_chunk;

    assign last_chunk = (idx_q == LAST_IDX);

    // Handshake flags depend only on the state register, so there is no
    // combinational path from in_valid or out_ready.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    // Select the operand slices addressed by idx. Each branch uses a
    // constant part-select, so this builds a plain NUM_CHUNKS-way mux.
    always_comb begin
        sum_slice   = '0;
        carry_slice = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sum_slice   = sum_q[i*CHUNK +: CHUNK];
                carry_slice = carry_q[i*CHUNK +: CHUNK];
            end
        end
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (sum_slice),
        .b    (carry_slice),
        .cin  (cr_q),
        .s    (add_s),
        .cout (add_c)
    );

    // State register.
    // NOTE: all clocked state uses non-blocking assignments, so every
    // register samples pre-edge values no matter how blocks are ordered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Flush overrides both handshakes.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (in_valid)   state_d = ADD;
                ADD:  if (last_chunk) state_d = DONE;
                DONE: if (out_ready)  state_d = IDLE;
                default:              state_d = IDLE;
            endcase
        end
    end

`ifdef CSA_RESOLVE_OVF_EN
    // The overflow flag is accumulated while the upper-half slices are
    // resolved. It is published together with cout when the last slice
    // completes.
    logic ovf_acc_q;
    logic ovf_q;
    logic upper_chunk;
    logic ovf_next;

    assign upper_chunk = (idx_q >= IDX_W'(NUM_CHUNKS / 2));
    assign ovf_next    = ovf_acc_q | (upper_chunk & (|add_s));
    assign ovf_o       = ovf_q;

    // Overflow accumulator and published flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_acc_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (!flush_i) begin
            if (state_q == IDLE && in_valid) begin
                ovf_acc_q <= 1'b0;
            end else if (state_q == ADD) begin
                ovf_acc_q <= ovf_next;
                if (last_chunk) begin
                    ovf_q <= ovf_next;
                end
            end
        end
    end
`endif

    // Datapath: latch operands on accept, then resolve one slice per
    // cycle. The product, tag and carry out stay unchanged in DONE, so
    // they remain stable while the arbiter stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            cr_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= '0;
            prod_q  <= '0;
            tag_q   <= '0;
            cout_q  <= 1'b0;
        end else if (flush_i) begin
            idx_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sum_q   <= sum_i;
                        carry_q <= carry_i;
                        tag_q   <= tag_i;
                        idx_q   <= '0;
                        cr_q    <= 1'b0;
                    end
                end
                ADD: begin
                    for (int i = 0; i < NUM_CHUNKS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            prod_q[i*CHUNK +: CHUNK] <= add_s;
                        end
                    end
                    cr_q <= add_c;
                    if (last_chunk) begin
                        idx_q  <= '0;
                        cout_q <= add_c;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign prod_o = prod_q;
    assign tag_o  = tag_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_csa_resolve_unit.sv
// Self-checking bench for csa_resolve_unit. The reference model is
// plain 65-bit arithmetic on the latched operands, plus a FIFO of
// expected results that tracks order across the handshake.
`timescale 1ns/1ps
module tb_csa_resolve_unit;
    import wallace_pkg::*;

    localparam int WIDTH = 64;
    localparam int TAG_W = 4;
    localparam int LAT   = NCHUNK;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_i;
    logic [WIDTH-1:0] carry_i;
    logic [TAG_W-1:0] tag_i;
    logic             flush_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] prod_o;
    logic [TAG_W-1:0] tag_o;
    logic             cout_o;
`ifdef CSA_RESOLVE_OVF_EN
    logic             ovf_o;
`endif

    csa_resolve_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_i     (sum_i),
        .carry_i   (carry_i),
        .tag_i     (tag_i),
        .flush_i   (flush_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod_o    (prod_o),
        .tag_o     (tag_o),
        .cout_o    (cout_o)
`ifdef CSA_RESOLVE_OVF_EN
        ,
        .ovf_o     (ovf_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] p;
        logic        c;
        logic        o;
        logic [3:0]  t;
    } exp_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Reference result: the full-precision sum, split into product,
    // carry out and upper-half-nonzero flag.
    function automatic exp_t model(input logic [63:0] s, input logic [63:0] c, input logic [3:0] t);
        logic [64:0] full;
        exp_t e;
        full = {1'b0, s} + {1'b0, c};
        e.p = full[63:0];
        e.c = full[64];
        e.o = (full[63:32] != 32'd0);
        e.t = t;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string name, input exp_t e);
        check({name, "_prod"}, prod_o, e.p);
        check({name, "_tag"}, 64'(tag_o), 64'(e.t));
        check({name, "_cout"}, 64'(cout_o), 64'(e.c));
`ifdef CSA_RESOLVE_OVF_EN
        check({name, "_ovf"}, 64'(ovf_o), 64'(e.o));
`endif
    endtask

    // Issue one pair, check its latency and result, then consume it.
    task automatic run_op(input string name, input logic [63:0] s, input logic [63:0] c,
                          input logic [3:0] t);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            step();
            cyc++;
        end
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        sum_i    = s;
        carry_i  = c;
        tag_i    = t;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            step();
            cyc++;
        end
        check({name, "_latency"}, 64'(cyc), 64'(LAT));
        check_result(name, model(s, c, t));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, "_consumed"}, 64'(out_valid), 64'd0);
    endtask

    exp_t exp_q[$];

    initial begin
        exp_t e;
        logic any_valid;
        int   cyc;
        int   sent;
        int   recv;
        logic have;
        logic [63:0] rs;
        logic [63:0] rc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush_i   = 1'b0;
        sum_i     = '0;
        carry_i   = '0;
        tag_i     = '0;

        // Reset state.
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_prod", prod_o, 64'd0);
        check("rst_tag", 64'(tag_o), 64'd0);
        check("rst_cout", 64'(cout_o), 64'd0);
`ifdef CSA_RESOLVE_OVF_EN
        check("rst_ovf", 64'(ovf_o), 64'd0);
`endif
        #1 rst_n = 1'b1;
        step();

        // Carry crossing chunk boundaries into the upper half.
        run_op("chain", 64'h0000_0000_FFFF_0000, 64'h0000_0000_0001_0000, 4'd3);
        // Full-width wrap.
        run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 4'd7);

        // Result held under backpressure; new input must be refused.
        sum_i = 64'h1234_5678_9ABC_DEF0; carry_i = 64'h0FED_CBA9_8765_4320; tag_i = 4'd9;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        e = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4320, 4'd9);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            step();
            cyc++;
        end
        check("stall_latency", 64'(cyc), 64'(LAT));
        sum_i = 64'hAAAA; carry_i = 64'h5555; tag_i = 4'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check_result("stall", e);
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stall_release_in_ready", 64'(in_ready), 64'd1);
        check("stall_release_out_valid", 64'(out_valid), 64'd0);
        any_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            any_valid |= out_valid;
        end
        check("stall_no_accept", 64'(any_valid), 64'd0);

        // Flush in the second ADD cycle.
        sum_i = 64'hDEAD_BEEF; carry_i = 64'h1; tag_i = 4'd4;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        any_valid = out_valid;
        for (int i = 0; i < 8; i++) begin
            step();
            any_valid |= out_valid;
        end
        check("flush_no_valid", 64'(any_valid), 64'd0);
        run_op("post_flush", 64'h5, 64'hA, 4'd2);

        // Reset pulse mid-ADD.
        sum_i = 64'hFFFF_0000_FFFF_0000; carry_i = 64'h0001_0000_0001_0000; tag_i = 4'd12;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("arst_prod", prod_o, 64'd0);
        check("arst_tag", 64'(tag_o), 64'd0);
        check("arst_cout", 64'(cout_o), 64'd0);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
`ifdef CSA_RESOLVE_OVF_EN
        check("arst_ovf", 64'(ovf_o), 64'd0);
`endif
        #1 rst_n = 1'b1;
        step();
        run_op("post_rst", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 4'd5);

        // Random back-to-back traffic with random arbiter stalls.
        sent = 0;
        recv = 0;
        cyc  = 0;
        have = 1'b0;
        while (recv < 1000 && cyc < 40000) begin
            if (!have && sent < 1000) begin
                case ($urandom_range(0, 7))
                    0:       begin rs = '1; rc = 64'(1); end
                    1:       begin rs = {32'd0, $urandom()}; rc = {32'd0, $urandom()}; end
                    default: begin rs = {$urandom(), $urandom()}; rc = {$urandom(), $urandom()}; end
                endcase
                sum_i   = rs;
                carry_i = rc;
                tag_i   = sent[3:0];
                have    = 1'b1;
            end
            in_valid  = have && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(sum_i, carry_i, tag_i));
                have = 1'b0;
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_spurious", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_result("rand", e);
                end
                recv++;
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rand_received", 64'(recv), 64'd1000);
        check("rand_leftover", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
